// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: control bit positions, default widths and
// the EX/MEM pipeline entry layout.
package mips_pkg;

    localparam int unsigned MIPS_DATA_W = 32;
    localparam int unsigned MIPS_REG_W  = 5;
    localparam int unsigned CTRL_W      = 5;

    // Bit positions inside the EX control vector {RegWrite, MemRead, MemWrite, MemtoReg, Branch}
    localparam int unsigned CTRL_BRANCH   = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;
    localparam int unsigned CTRL_MEMWRITE = 2;
    localparam int unsigned CTRL_MEMREAD  = 3;
    localparam int unsigned CTRL_REGWRITE = 4;

    typedef struct packed {
        logic [MIPS_DATA_W-1:0] result;
        logic [MIPS_DATA_W-1:0] wdata;
        logic [MIPS_REG_W-1:0]  wreg;
        logic [CTRL_W-1:0]      ctrl;
        logic                   bne;
        logic [MIPS_DATA_W-1:0] btarget;
    } ex_mem_entry_t;

    // beq is taken on a zero result, bne on a non-zero result.
    function automatic logic branch_taken(input logic branch, input logic bne,
                                          input logic [MIPS_DATA_W-1:0] result);
        return branch & ((result == '0) ^ bne);
    endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic two-entry valid/ready buffer. The output register feeds the consumer;
// the skid entry catches the one transfer that slips in while the producer has
// not yet seen the registered ready drop. in_ready_o is a flop, so there is no
// combinational path from out_ready_i to in_ready_o.
module skid_buf #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o,
    // Pulses when a new entry is written into the output register this cycle
    output logic             load_o,
    output logic [Width-1:0] load_data_o
);

    logic             out_valid_q, out_valid_d;
    logic [Width-1:0] out_data_q,  out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [Width-1:0] skid_data_q,  skid_data_d;
    logic             in_ready_q,  in_ready_d;

    logic in_fire;
    logic out_space;
    logic load;

    // Handshake decode; in_ready_q == ~skid_valid_q, so a skid entry and an
    // input transfer never compete for the output register.
    always_comb begin
        in_fire     = in_valid_i & in_ready_q;
        out_space   = ~out_valid_q | out_ready_i;
        load        = ~flush_i & out_space & (skid_valid_q | in_fire);
        load_data_o = skid_valid_q ? skid_data_q : in_data_i;
    end

    // Next-state for output register, skid entry and registered ready
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            // A concurrent consumer transfer still completes; everything held is dropped
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_space) begin
            out_valid_d  = skid_valid_q | in_fire;
            skid_valid_d = 1'b0;
            if (load) begin
                out_data_d = load_data_o;
            end
        end else if (in_fire) begin
            // Output stalled: park the accepted entry in the skid
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
        in_ready_d = ~skid_valid_d;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign load_o      = load;

endmodule

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline boundary. Buffers the ALU result, store data, destination
// register and MEM/WB control through a two-entry skid buffer, keeps a
// registered zero flag of the held result and resolves beq/bne as an entry
// enters the output register, pulsing br_taken for one cycle.
module ex_mem_skid
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = MIPS_DATA_W,
    parameter int unsigned REG_W  = MIPS_REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [REG_W-1:0]  ex_wreg,
    input  logic [4:0]        ex_ctrl,
    input  logic              ex_bne,
    input  logic [DATA_W-1:0] ex_btarget,
    input  logic              flush,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [REG_W-1:0]  mem_wreg,
    output logic [3:0]        mem_ctrl,
    output logic              mem_zero,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target
);

    localparam int unsigned EntryW = $bits(ex_mem_entry_t);

    ex_mem_entry_t in_entry;
    ex_mem_entry_t out_entry;
    ex_mem_entry_t load_entry;
    logic          load;

    logic              zero_q,      zero_d;
    logic              br_taken_q,  br_taken_d;
    logic [DATA_W-1:0] br_target_q, br_target_d;

    // Pack the EX stage fields into one payload
    always_comb begin
        in_entry         = '0;
        in_entry.result  = ex_result;
        in_entry.wdata   = ex_wdata;
        in_entry.wreg    = ex_wreg;
        in_entry.ctrl    = ex_ctrl;
        in_entry.bne     = ex_bne;
        in_entry.btarget = ex_btarget;
    end

    skid_buf #(
        .Width (EntryW)
    ) u_skid_buf (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (ex_valid),
        .in_ready_o  (ex_ready),
        .in_data_i   (in_entry),
        .out_valid_o (mem_valid),
        .out_ready_i (mem_ready),
        .out_data_o  (out_entry),
        .load_o      (load),
        .load_data_o (load_entry)
    );

    // Zero flag and branch decision follow the entry being written into the
    // output register; flush already suppresses load, so no taken pulse on flush.
    always_comb begin
        zero_d      = load ? (load_entry.result == '0) : zero_q;
        br_taken_d  = load & branch_taken(load_entry.ctrl[CTRL_BRANCH], load_entry.bne,
                                          load_entry.result);
        br_target_d = br_taken_d ? load_entry.btarget : br_target_q;
    end

    // Registered zero flag and branch redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q      <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            zero_q      <= zero_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
        end
    end

    // Branch information is consumed here; MEM sees only the four MEM/WB bits
    assign mem_result = out_entry.result;
    assign mem_wdata  = out_entry.wdata;
    assign mem_wreg   = out_entry.wreg;
    assign mem_ctrl   = out_entry.ctrl[CTRL_W-1:1];
    assign mem_zero   = zero_q;
    assign br_taken   = br_taken_q;
    assign br_target  = br_target_q;

    logic unused_bits;
    assign unused_bits = ^{out_entry.ctrl[CTRL_BRANCH], out_entry.bne, out_entry.btarget,
                           load_entry.wdata, load_entry.wreg, load_entry.ctrl[CTRL_W-1:1]};

endmodule

// File: tb/tb_ex_mem_skid.sv
// Self-checking bench for ex_mem_skid: scoreboard on the MEM side plus
// directed checks of reset, streaming, backpressure, branch, flush and reset.
module tb_ex_mem_skid;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_result = '0;
    logic [31:0] ex_wdata = '0;
    logic [4:0]  ex_wreg = '0;
    logic [4:0]  ex_ctrl = '0;
    logic        ex_bne = 1'b0;
    logic [31:0] ex_btarget = '0;
    logic        flush = 1'b0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_result;
    logic [31:0] mem_wdata;
    logic [4:0]  mem_wreg;
    logic [3:0]  mem_ctrl;
    logic        mem_zero;
    logic        br_taken;
    logic [31:0] br_target;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic [3:0]  ctrl;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ex_mem_skid dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_result  (ex_result),
        .ex_wdata   (ex_wdata),
        .ex_wreg    (ex_wreg),
        .ex_ctrl    (ex_ctrl),
        .ex_bne     (ex_bne),
        .ex_btarget (ex_btarget),
        .flush      (flush),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_result (mem_result),
        .mem_wdata  (mem_wdata),
        .mem_wreg   (mem_wreg),
        .mem_ctrl   (mem_ctrl),
        .mem_zero   (mem_zero),
        .br_taken   (br_taken),
        .br_target  (br_target)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] r, input logic [31:0] w, input logic [4:0] wr,
                         input logic [4:0] c, input logic b, input logic [31:0] t);
        ex_valid   = 1'b1;
        ex_result  = r;
        ex_wdata   = w;
        ex_wreg    = wr;
        ex_ctrl    = c;
        ex_bne     = b;
        ex_btarget = t;
    endtask

    // Scoreboard: sampled mid-cycle, where all handshake signals are settled
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (mem_valid && mem_ready) begin
                check("sb_has_entry", {63'b0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_result", {32'b0, mem_result}, {32'b0, e.result});
                    check("sb_wdata", {32'b0, mem_wdata}, {32'b0, e.wdata});
                    check("sb_wreg", {59'b0, mem_wreg}, {59'b0, e.wreg});
                    check("sb_ctrl", {60'b0, mem_ctrl}, {60'b0, e.ctrl});
                end
            end
            if (flush) begin
                sb.delete();
            end else if (ex_valid && ex_ready) begin
                sb.push_back('{result: ex_result, wdata: ex_wdata, wreg: ex_wreg,
                               ctrl: ex_ctrl[4:1]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // 1. Reset held with EX offering
        drive(32'h99, 32'h1234, 5'd7, 5'b11000, 1'b0, 32'h0);
        mem_ready = 1'b1;
        repeat (3) tick();
        check("rst_mem_valid", {63'b0, mem_valid}, 64'd0);
        check("rst_br_taken", {63'b0, br_taken}, 64'd0);
        check("rst_ex_ready", {63'b0, ex_ready}, 64'd1);
        check("rst_result", {32'b0, mem_result}, 64'd0);
        check("rst_wdata", {32'b0, mem_wdata}, 64'd0);
        check("rst_wreg", {59'b0, mem_wreg}, 64'd0);
        check("rst_ctrl", {60'b0, mem_ctrl}, 64'd0);
        check("rst_zero", {63'b0, mem_zero}, 64'd0);
        check("rst_target", {32'b0, br_target}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("first_valid", {63'b0, mem_valid}, 64'd1);
        check("first_result", {32'b0, mem_result}, 64'h99);

        // 2. Streaming, no bubbles
        for (int i = 0; i < 8; i++) begin
            drive(32'h10 + i, 32'h100 + i, 5'(i + 1), 5'b10010, 1'b0, 32'h0);
            tick();
            check("stream_valid", {63'b0, mem_valid}, 64'd1);
            check("stream_result", {32'b0, mem_result}, 64'h10 + 64'(i));
            check("stream_ready", {63'b0, ex_ready}, 64'd1);
        end
        ex_valid = 1'b0;
        tick();
        check("stream_drained", {63'b0, mem_valid}, 64'd0);

        // 3. Backpressure
        mem_ready = 1'b0;
        drive(32'hA, 32'h0, 5'd1, 5'b10000, 1'b0, 32'h0);
        tick();
        check("bp_a_out", {32'b0, mem_result}, 64'hA);
        check("bp_ready_a", {63'b0, ex_ready}, 64'd1);
        drive(32'hB, 32'h0, 5'd2, 5'b10000, 1'b0, 32'h0);
        tick();
        check("bp_ready_fall", {63'b0, ex_ready}, 64'd0);
        check("bp_hold_a", {32'b0, mem_result}, 64'hA);
        drive(32'hC, 32'h0, 5'd3, 5'b10000, 1'b0, 32'h0);
        repeat (2) tick();
        check("bp_ready_low", {63'b0, ex_ready}, 64'd0);
        check("bp_valid_held", {63'b0, mem_valid}, 64'd1);
        check("bp_hold_a2", {32'b0, mem_result}, 64'hA);
        mem_ready = 1'b1;
        tick();
        check("bp_out_b", {32'b0, mem_result}, 64'hB);
        check("bp_ready_rise", {63'b0, ex_ready}, 64'd1);
        tick();
        check("bp_out_c", {32'b0, mem_result}, 64'hC);
        ex_valid = 1'b0;
        tick();
        check("bp_drained", {63'b0, mem_valid}, 64'd0);

        // 4. Branch resolution
        drive(32'h0, 32'h0, 5'd0, 5'b00001, 1'b0, 32'h0040_0020);
        tick();
        check("beq_taken", {63'b0, br_taken}, 64'd1);
        check("beq_target", {32'b0, br_target}, 64'h0040_0020);
        check("beq_zero", {63'b0, mem_zero}, 64'd1);
        check("beq_ctrl", {60'b0, mem_ctrl}, 64'd0);
        ex_valid = 1'b0;
        tick();
        check("beq_pulse_end", {63'b0, br_taken}, 64'd0);
        drive(32'h0, 32'h0, 5'd0, 5'b00001, 1'b1, 32'h0000_0100);
        tick();
        check("bne_zero_not_taken", {63'b0, br_taken}, 64'd0);
        check("bne_zero_flag", {63'b0, mem_zero}, 64'd1);
        drive(32'h5, 32'h0, 5'd0, 5'b00001, 1'b1, 32'h0040_0040);
        tick();
        check("bne_taken", {63'b0, br_taken}, 64'd1);
        check("bne_target", {32'b0, br_target}, 64'h0040_0040);
        check("bne_nonzero", {63'b0, mem_zero}, 64'd0);
        ex_valid = 1'b0;
        tick();
        check("bne_pulse_end", {63'b0, br_taken}, 64'd0);

        // 5a. Flush with output and skid full, EX offering a taken beq
        mem_ready = 1'b0;
        drive(32'h1, 32'h0, 5'd4, 5'b10000, 1'b0, 32'h0);
        tick();
        drive(32'h2, 32'h0, 5'd5, 5'b10000, 1'b0, 32'h0);
        tick();
        check("fl_full_ready", {63'b0, ex_ready}, 64'd0);
        drive(32'h0, 32'h0, 5'd0, 5'b00001, 1'b0, 32'h0040_0060);
        flush = 1'b1;
        tick();
        check("fl_valid", {63'b0, mem_valid}, 64'd0);
        check("fl_ready", {63'b0, ex_ready}, 64'd1);
        check("fl_no_branch", {63'b0, br_taken}, 64'd0);
        flush = 1'b0;
        ex_valid = 1'b0;
        tick();
        check("fl_discarded", {63'b0, mem_valid}, 64'd0);
        // 5b. Flush against a load straight from EX of a taken beq
        mem_ready = 1'b1;
        drive(32'h0, 32'h0, 5'd0, 5'b00001, 1'b0, 32'h0040_0080);
        flush = 1'b1;
        tick();
        check("fl_ex_valid", {63'b0, mem_valid}, 64'd0);
        check("fl_ex_no_branch", {63'b0, br_taken}, 64'd0);
        flush = 1'b0;
        ex_valid = 1'b0;
        tick();
        // 5c. Flush with a MEM transfer in the same cycle
        drive(32'h77, 32'h55, 5'd9, 5'b11000, 1'b0, 32'h0);
        tick();
        check("fl_mem_pre", {63'b0, mem_valid}, 64'd1);
        ex_valid = 1'b0;
        flush = 1'b1;
        tick();
        check("fl_mem_post", {63'b0, mem_valid}, 64'd0);
        flush = 1'b0;

        // 6. Async reset mid-stall
        mem_ready = 1'b0;
        drive(32'h31, 32'h0, 5'd1, 5'b10000, 1'b0, 32'h0);
        tick();
        drive(32'h32, 32'h0, 5'd2, 5'b10000, 1'b0, 32'h0);
        tick();
        check("ar_stalled", {63'b0, ex_ready}, 64'd0);
        ex_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {63'b0, mem_valid}, 64'd0);
        check("ar_ready", {63'b0, ex_ready}, 64'd1);
        check("ar_result", {32'b0, mem_result}, 64'd0);
        check("ar_wreg", {59'b0, mem_wreg}, 64'd0);
        tick();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        repeat (2) tick();
        check("ar_no_stale", {63'b0, mem_valid}, 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
